// File: rtl/sms_power_engine.sv
// Per-lane GF(2^6) exponentiation x^E by MSB-first square-and-multiply in GF((2^3)^2) tower arithmetic.
// Polynomial-basis ports (modulus x^6+x+1) are mapped into and out of the tower basis when ISO_EN=1.
module sms_power_engine #(
    parameter int LANES  = 1,
    parameter int ISO_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6*LANES-1:0]   in_x,
    input  logic [5:0]           in_exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [6*LANES-1:0]   out_y,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Tower element {h, l} = h*Y + l with Y^2 = Y + NU; GF(8) digits use the normal basis {b, b^2, b^4}.
    localparam logic [5:0] TOWER_ONE = 6'h07;
    localparam logic [2:0] NU        = 3'b001;

    function automatic logic [2:0] gf8_mul(input logic [2:0] a, input logic [2:0] b);
        logic p01, p02, p12;
        p01 = (a[0] & b[1]) ^ (a[1] & b[0]);
        p02 = (a[0] & b[2]) ^ (a[2] & b[0]);
        p12 = (a[1] & b[2]) ^ (a[2] & b[1]);
        return {(a[1] & b[1]) ^ p01 ^ p02,
                (a[0] & b[0]) ^ p02 ^ p12,
                (a[2] & b[2]) ^ p01 ^ p12};
    endfunction

    function automatic logic [2:0] gf8_sq(input logic [2:0] a);
        return {a[1], a[0], a[2]};
    endfunction

    function automatic logic [5:0] gf64_mul(input logic [5:0] a, input logic [5:0] b);
        logic [2:0] hh;
        hh = gf8_mul(a[5:3], b[5:3]);
        return {hh ^ gf8_mul(a[5:3], b[2:0]) ^ gf8_mul(a[2:0], b[5:3]),
                gf8_mul(hh, NU) ^ gf8_mul(a[2:0], b[2:0])};
    endfunction

    function automatic logic [5:0] gf64_sq(input logic [5:0] a);
        logic [2:0] hs;
        hs = gf8_sq(a[5:3]);
        return {hs, gf8_mul(hs, NU) ^ gf8_sq(a[2:0])};
    endfunction

    function automatic logic [5:0] lin_map(input logic [35:0] cols, input logic [5:0] v);
        logic [5:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            if (v[i]) r = r ^ cols[6*i +: 6];
        end
        return r;
    endfunction

    // Column i is r^i, where r is the smallest tower root of x^6+x+1.
    function automatic logic [35:0] build_iso();
        logic [35:0] cols;
        logic [5:0]  p;
        logic        found;
        cols  = '0;
        found = 1'b0;
        for (int r = 1; r < 64; r++) begin
            p = TOWER_ONE;
            for (int k = 0; k < 6; k++) p = gf64_mul(p, 6'(r));
            if (!found && ((p ^ 6'(r) ^ TOWER_ONE) == 6'h00)) begin
                found = 1'b1;
                p     = TOWER_ONE;
                for (int i = 0; i < 6; i++) begin
                    cols[6*i +: 6] = p;
                    p = gf64_mul(p, 6'(r));
                end
            end
        end
        return cols;
    endfunction

    function automatic logic [35:0] build_inv(input logic [35:0] fwd);
        logic [35:0] cols;
        cols = '0;
        for (int j = 0; j < 6; j++) begin
            for (int q = 0; q < 64; q++) begin
                if (lin_map(fwd, 6'(q)) == 6'(1 << j)) cols[6*j +: 6] = 6'(q);
            end
        end
        return cols;
    endfunction

    localparam logic [35:0] ISO_COLS = build_iso();
    localparam logic [35:0] INV_COLS = build_inv(ISO_COLS);

    state_t               state, state_next;
    logic [6*LANES-1:0]   base, acc, acc_step, x_tower, y_poly;
    logic [5:0]           exp_r;
    logic [2:0]           cnt;
    logic                 exp_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)    state_next = RUN;
            RUN:     if (cnt == 3'd0) state_next = DONE;
            DONE:    if (out_ready)   state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // One square-and-multiply step per lane, plus the basis conversions at the boundaries.
    always_comb begin
        x_tower  = '0;
        acc_step = '0;
        y_poly   = '0;
        exp_bit  = exp_r[cnt];
        for (int i = 0; i < LANES; i++) begin
            acc_step[6*i +: 6] = exp_bit ? gf64_mul(gf64_sq(acc[6*i +: 6]), base[6*i +: 6])
                                         : gf64_sq(acc[6*i +: 6]);
            x_tower[6*i +: 6]  = (ISO_EN != 0) ? lin_map(ISO_COLS, in_x[6*i +: 6]) : in_x[6*i +: 6];
            y_poly[6*i +: 6]   = (ISO_EN != 0) ? lin_map(INV_COLS, acc_step[6*i +: 6])
                                               : acc_step[6*i +: 6];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base  <= '0;
            acc   <= '0;
            exp_r <= '0;
            cnt   <= '0;
            out_y <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        base  <= x_tower;
                        exp_r <= in_exp;
                        acc   <= {LANES{TOWER_ONE}};
                        cnt   <= 3'd5;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    if (cnt == 3'd0) out_y <= y_poly;
                    else             cnt   <= cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sms_power_engine.sv
// Directed bench for sms_power_engine: a LANES=1 and a LANES=4 instance checked against a
// polynomial-basis GF(2^6) model (modulus x^6+x+1) through a scoreboard queue.
module tb_sms_power_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [5:0]  in_x, in_exp, out_y;
    logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [23:0] in_x4, out_y4;
    logic [5:0]  in_exp4;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [23:0] sb_q[$];

    always #5 clk = ~clk;

    sms_power_engine #(.LANES(1), .ISO_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_exp(in_exp), .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .busy(busy)
    );

    sms_power_engine #(.LANES(4), .ISO_EN(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_x(in_x4), .in_exp(in_exp4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_y(out_y4), .busy(busy4)
    );

    function automatic logic [5:0] pmul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] p, aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[4:0], 1'b0} ^ (aa[5] ? 6'h03 : 6'h00);
        end
        return p;
    endfunction

    function automatic logic [5:0] ppow(input logic [5:0] x, input int e);
        logic [5:0] r;
        r = 6'h01;
        for (int i = 0; i < e; i++) r = pmul(r, x);
        return r;
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic pop_expected(input string tag, output logic [23:0] expv);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 24'd0, 24'd1);
            expv = '0;
        end else begin
            expv = sb_q.pop_front();
        end
    endtask

    task automatic applyStimulus(input logic [5:0] x, input logic [5:0] e, input logic [5:0] expv);
        check("in_ready_before_accept", {23'd0, in_ready}, 24'd1);
        in_valid = 1'b1;
        in_x     = x;
        in_exp   = e;
        sb_q.push_back({18'd0, expv});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 24'(cyc), 24'd6);
    endtask

    task automatic checkOutput(input string tag);
        logic [23:0] expv;
        wait_valid(tag);
        pop_expected(tag, expv);
        check({tag, "_out_y"}, {18'd0, out_y}, expv);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, {23'd0, out_valid}, 24'd0);
        check({tag, "_busy_drop"}, {23'd0, busy}, 24'd0);
    endtask

    task automatic run_quad(input string tag, input logic [23:0] x, input logic [5:0] e);
        logic [23:0] expv, obs;
        int          cyc;
        for (int i = 0; i < 4; i++) expv[6*i +: 6] = ppow(x[6*i +: 6], int'(e));
        sb_q.push_back(expv);
        in_valid4 = 1'b1;
        in_x4     = x;
        in_exp4   = e;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        cyc = 0;
        while (!out_valid4 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 24'(cyc), 24'd6);
        pop_expected(tag, expv);
        obs = out_y4;
        check({tag, "_out_y"}, obs, expv);
        if (e == 6'd62) begin
            for (int i = 1; i < 4; i++) check({tag, "_inv_product"}, {18'd0, pmul(x[6*i +: 6], obs[6*i +: 6])}, 24'h01);
        end
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        check({tag, "_valid_drop"}, {23'd0, out_valid4}, 24'd0);
    endtask

    initial begin
        logic [23:0] expv;
        logic [5:0]  y;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_x       = '0;
        in_exp     = '0;
        out_ready  = 1'b0;
        in_valid4  = 1'b0;
        in_x4      = '0;
        in_exp4    = '0;
        out_ready4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {23'd0, in_ready}, 24'd1);
        check("rst_out_valid", {23'd0, out_valid}, 24'd0);
        check("rst_busy", {23'd0, busy}, 24'd0);
        check("rst_out_y", {18'd0, out_y}, 24'd0);
        check("rst_out_y4", out_y4, 24'd0);
        check("rst_busy4", {22'd0, busy4, in_ready4}, 24'd1);

        // Accepted on the very first edge after reset release.
        rst_n = 1'b1;
        applyStimulus(6'h2B, 6'd1, 6'h2B);
        checkOutput("x2b_e1");

        applyStimulus(6'h00, 6'd0, 6'h01);
        checkOutput("x00_e0");
        applyStimulus(6'h15, 6'd0, 6'h01);
        checkOutput("x15_e0");
        applyStimulus(6'h15, 6'd63, 6'h01);
        checkOutput("x15_e63");
        applyStimulus(6'h00, 6'd17, 6'h00);
        checkOutput("x00_e17");

        // Stall in DONE while a competing operand is offered.
        applyStimulus(6'h1D, 6'd5, ppow(6'h1D, 5));
        wait_valid("stall");
        expv     = sb_q[0];
        in_valid = 1'b1;
        in_x     = 6'h3C;
        in_exp   = 6'd3;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("stall_out_valid", {23'd0, out_valid}, 24'd1);
            check("stall_out_y", {18'd0, out_y}, expv);
            check("stall_in_ready", {23'd0, in_ready}, 24'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("stall_release_valid", {23'd0, out_valid}, 24'd0);
        check("stall_no_take_on_release", {23'd0, busy}, 24'd0);
        pop_expected("stall", expv);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("stall_no_second", {22'd0, out_valid, busy}, 24'd0);
        end

        for (int x = 0; x < 64; x++) begin
            y = ppow(6'(x), 17);
            applyStimulus(6'(x), 6'd17, y);
            checkOutput("sweep_e17");
            applyStimulus(y, 6'd26, 6'(x));
            checkOutput("sweep_e26");
        end

        // Reset three edges into a run discards it.
        applyStimulus(6'h2B, 6'd9, ppow(6'h2B, 9));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.delete();
        check("abort_in_ready", {23'd0, in_ready}, 24'd1);
        check("abort_out_valid", {23'd0, out_valid}, 24'd0);
        check("abort_busy", {23'd0, busy}, 24'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("abort_no_pulse", {23'd0, out_valid}, 24'd0);
        end
        applyStimulus(6'h07, 6'd2, 6'h15);
        checkOutput("after_abort_x07_e2");

        run_quad("quad_e62", {6'h2A, 6'h3F, 6'h01, 6'h00}, 6'd62);
        run_quad("quad_e1", {6'h2A, 6'h3F, 6'h01, 6'h00}, 6'd1);
        run_quad("quad_e45", {6'h11, 6'h22, 6'h33, 6'h3E}, 6'd45);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
